seq_detector_param: RTL and testbench



---
 rtl/seq_pkg.sv | 31 +++
 rtl/seq_pat_regs.sv | 43 ++++
 rtl/seq_detector_param.sv | 131 +++++++++++++
 tb/tb_seq_detector_param.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the run-length-tolerant sequence detector.
//   stage_w()     : width needed to encode a match stage 0..depth
//   default_sym() : reset value of pattern slot idx, (idx+1) mod 2^sym_w
//   STAGE_IDLE    : stage value meaning "nothing matched yet"
//   step_e        : kind of stage transition taken for one accepted symbol
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam int unsigned STAGE_IDLE = 0;

  typedef enum logic [1:0] {
    STEP_CLEAR,    // no rule matched, back to idle
    STEP_RESTART,  // symbol equals pat[0], start a fresh match at stage 1
    STEP_HOLD,     // symbol repeats the last matched pattern symbol
    STEP_ADVANCE   // symbol is the next pattern symbol
  } step_e;

  function automatic int unsigned stage_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned default_sym(input int unsigned idx,
                                              input int unsigned sym_w);
    longint unsigned modulus;
    modulus = longint'(1) << sym_w;
    return int'((longint'(idx) + 1) % modulus);
  endfunction

endpackage

// File: rtl/seq_pat_regs.sv
// -----------------------------------------------------------------------------
// seq_pat_regs
// DEPTH x SYM_W pattern register file. Resets asynchronously to the default
// pattern 1,2,3,... (mod 2^SYM_W); one write port. Writes to slots >= DEPTH
// are ignored.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cfg_we     : write strobe
//   cfg_idx    : slot to write
//   cfg_sym    : value to write
//   pat        : all slots, flat; slot i is pat[i*SYM_W +: SYM_W]
// -----------------------------------------------------------------------------
module seq_pat_regs
  import seq_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int DEPTH = 3,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [SYM_W-1:0]       cfg_sym,
  output logic [DEPTH*SYM_W-1:0] pat
);

  // NOTE: the pattern is reset to its default values like any other state;
  // the detector must work straight out of reset without being programmed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pat[i*SYM_W +: SYM_W] <= SYM_W'(default_sym(i, SYM_W));
      end
    end else if (cfg_we) begin
      // Slot decode by equality: an index >= DEPTH matches no slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (cfg_idx == IDX_W'(i)) pat[i*SYM_W +: SYM_W] <= cfg_sym;
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Run-length-tolerant detector for a programmable pattern of DEPTH symbols;
// every pattern symbol may repeat any number of consecutive times.
// Optional feature macro: SEQ_DETECTOR_MATCH_CNT_EN (adds match_cnt).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : in_sym is consumed this cycle
//   in_sym       : input symbol
//   cfg_we       : pattern write strobe (wins over in_valid, clears stage)
//   cfg_idx      : pattern slot to write
//   cfg_sym      : symbol value to write
//   ans          : high while stage == DEPTH
//   match_pulse  : one-cycle pulse after entering stage DEPTH
//   stage        : current match stage 0..DEPTH
//   match_cnt    : saturating count of match pulses (macro builds only)
// -----------------------------------------------------------------------------
module seq_detector_param
  import seq_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int DEPTH = 3,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [SYM_W-1:0]              in_sym,
  input  logic                          cfg_we,
  input  logic [$clog2(DEPTH)-1:0]      cfg_idx,
  input  logic [SYM_W-1:0]              cfg_sym,
  output logic                          ans,
  output logic                          match_pulse,
  output logic [stage_w(DEPTH)-1:0]     stage
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]              match_cnt
`endif
);

  localparam int ST_W  = stage_w(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ST_W-1:0] STAGE_ZERO = ST_W'(STAGE_IDLE);
  localparam logic [ST_W-1:0] STAGE_ONE  = ST_W'(1);
  localparam logic [ST_W-1:0] STAGE_FULL = ST_W'(DEPTH);

  logic [DEPTH*SYM_W-1:0] pat;
  logic [ST_W-1:0]        stage_q, stage_d;
  logic                   pulse_d;
  logic [SYM_W-1:0]       prev_sym, cur_sym;
  logic                   has_prev, has_next;
  step_e                  step;

  seq_pat_regs #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_pat (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_we  (cfg_we),
    .cfg_idx (cfg_idx),
    .cfg_sym (cfg_sym),
    .pat     (pat)
  );

  // NOTE: every signal is given a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    prev_sym = '0;
    cur_sym  = '0;
    step     = STEP_CLEAR;
    stage_d  = stage_q;

    // prev_sym = pat[k-1] (last matched), cur_sym = pat[k] (next expected).
    for (int i = 0; i < DEPTH; i++) begin
      if (stage_q == ST_W'(i + 1)) prev_sym = pat[i*SYM_W +: SYM_W];
      if (stage_q == ST_W'(i))     cur_sym  = pat[i*SYM_W +: SYM_W];
    end
    has_prev = (stage_q != STAGE_ZERO);
    has_next = (stage_q != STAGE_FULL);

    // Repeat is tested before advance, so a pattern with pat[k-1]==pat[k]
    // parks at stage k forever; that is intended behaviour.
    if (has_prev && in_sym == prev_sym)     step = STEP_HOLD;
    else if (has_next && in_sym == cur_sym) step = STEP_ADVANCE;
    else if (in_sym == pat[0 +: SYM_W])     step = STEP_RESTART;
    else                                    step = STEP_CLEAR;

    if (cfg_we) begin
      stage_d = STAGE_ZERO;  // pattern changed: any partial match is void
    end else if (in_valid) begin
      case (step)
        STEP_HOLD:    stage_d = stage_q;
        STEP_ADVANCE: stage_d = stage_q + STAGE_ONE;
        STEP_RESTART: stage_d = STAGE_ONE;
        default:      stage_d = STAGE_ZERO;
      endcase
    end

    // Pulse only on entry into the full stage, never while holding there.
    pulse_d = (stage_d == STAGE_FULL) && (stage_q != STAGE_FULL);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= STAGE_ZERO;
      match_pulse <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      match_pulse <= pulse_d;
    end
  end

  assign stage = stage_q;
  assign ans   = (stage_q == STAGE_FULL);

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
  // Counts each cycle in which match_pulse is high; saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (match_pulse && match_cnt != '1) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Self-checking bench for seq_detector_param (SYM_W=2, DEPTH=3, CNT_W=8).
// Directed scenarios followed by a randomized phase, all compared against a
// reference model of the matching rules kept in integer arithmetic.
// Build with SEQ_DETECTOR_MATCH_CNT_EN defined to also cover match_cnt.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  localparam int SYM_W   = 2;
  localparam int DEPTH   = 3;
  localparam int CNT_W   = 8;
  localparam int ST_W    = $clog2(DEPTH + 1);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int SYM_MOD = 1 << SYM_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             in_valid = 1'b0;
  logic [SYM_W-1:0] in_sym   = '0;
  logic             cfg_we   = 1'b0;
  logic [IDX_W-1:0] cfg_idx  = '0;
  logic [SYM_W-1:0] cfg_sym  = '0;
  logic             ans;
  logic             match_pulse;
  logic [ST_W-1:0]  stage;
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int pat_m [DEPTH];
  int k_m;
  bit pulse_m;
  int cnt_m;

  always #5 clk = ~clk;

  seq_detector_param #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_sym      (in_sym),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_sym     (cfg_sym),
    .ans         (ans),
    .match_pulse (match_pulse),
    .stage       (stage)
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    ,
    .match_cnt   (match_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k_m     = 0;
    pulse_m = 0;
    cnt_m   = 0;
    for (int i = 0; i < DEPTH; i++) pat_m[i] = (i + 1) % SYM_MOD;
  endtask

  // Matching rules: repeat of the last matched symbol, then the next
  // expected symbol, then a fresh start on pat[0], else back to zero.
  function automatic int next_stage(input int k, input int s);
    if (k > 0 && s == pat_m[k-1]) return k;
    if (k < DEPTH && s == pat_m[k]) return k + 1;
    if (s == pat_m[0]) return 1;
    return 0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".stage"}, 32'(stage), k_m);
    check({tag, ".ans"},   32'(ans),   (k_m == DEPTH) ? 1 : 0);
    check({tag, ".pulse"}, 32'(match_pulse), 32'(pulse_m));
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    check({tag, ".cnt"},   32'(match_cnt), cnt_m);
`endif
  endtask

  // One clock cycle: drive after the falling edge, update the model at the
  // rising edge, compare 1 ns later.
  task automatic step(input string tag, input bit v, input int s,
                      input bit we = 0, input int idx = 0, input int csym = 0);
    int nk;
    @(negedge clk);
    in_valid = v;
    in_sym   = SYM_W'(s);
    cfg_we   = we;
    cfg_idx  = IDX_W'(idx);
    cfg_sym  = SYM_W'(csym);
    @(posedge clk);
    if (pulse_m && cnt_m < CNT_MAX) cnt_m++;
    if (we) begin
      if (idx < DEPTH) pat_m[idx] = csym % SYM_MOD;
      k_m     = 0;
      pulse_m = 0;
    end else if (v) begin
      nk      = next_stage(k_m, s % SYM_MOD);
      pulse_m = (nk == DEPTH) && (k_m != DEPTH);
      k_m     = nk;
    end else begin
      pulse_m = 0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic feed(input string tag, input int syms[$]);
    foreach (syms[i]) step($sformatf("%s[%0d]", tag, i), 1'b1, syms[i]);
  endtask

  initial begin
    model_reset();

    // Reset state while rst_n is low.
    #3;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic match.
    feed("basic", '{1, 2, 3});
    check("basic.ans_const", 32'(ans), 1);
    step("basic.after", 1'b1, 3);
    check("basic.pulse_once", 32'(match_pulse), 0);

    // Run-lengths.
    feed("runlen", '{0, 1, 1, 2, 2, 2, 3, 3});
    check("runlen.ans_const", 32'(ans), 1);

    // Breaks.
    feed("brk_a", '{0, 1, 2, 3, 2});
    check("brk_a.stage_const", 32'(stage), 0);
    feed("brk_b", '{0, 1, 2, 1});
    check("brk_b.stage_const", 32'(stage), 1);
    feed("brk_c", '{0, 1, 0});
    check("brk_c.stage_const", 32'(stage), 0);
    feed("brk_d", '{0, 1, 3});
    check("brk_d.stage_const", 32'(stage), 0);

    // Valid gap holds state.
    feed("gap", '{0, 1});
    repeat (5) step("gap.idle", 1'b0, 2);
    check("gap.held_const", 32'(stage), 1);
    feed("gap_tail", '{2, 3});
    check("gap.ans_const", 32'(ans), 1);

    // cfg_we beats in_valid: symbol 3 at stage 2 is dropped.
    feed("prio", '{0, 1, 2});
    step("prio.cfg", 1'b1, 3, 1'b1, 2, 3);
    check("prio.stage_const", 32'(stage), 0);

    // Write to a slot >= DEPTH: ignored, but stage still cleared.
    feed("badidx", '{1, 2});
    step("badidx.cfg", 1'b0, 0, 1'b1, 3, 0);
    check("badidx.stage_const", 32'(stage), 0);
    feed("badidx.chk", '{1, 2, 3});
    check("badidx.pat_kept", 32'(ans), 1);

    // Reprogram to 2,0,1.
    step("prog0", 1'b0, 0, 1'b1, 0, 2);
    step("prog1", 1'b0, 0, 1'b1, 1, 0);
    step("prog2", 1'b0, 0, 1'b1, 2, 1);
    feed("reprog", '{2, 0, 1});
    check("reprog.ans_const", 32'(ans), 1);

    // Counter saturation.
    repeat (300) feed("sat", '{2, 0, 1});
    step("sat.tail", 1'b0, 0);
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    check("sat.cnt_const", 32'(match_cnt), CNT_MAX);
`endif

    // Asynchronous reset mid-cycle at stage 2.
    feed("areset", '{3, 2, 0});
    check("areset.pre_stage", 32'(stage), 2);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("areset.now");
    @(negedge clk);
    rst_n = 1'b1;
    feed("areset.defpat", '{1, 2, 3});
    check("areset.defpat_const", 32'(ans), 1);

    // Randomized phase, including occasional pattern writes.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4)
        step("rand.cfg", 1'b1, $urandom_range(0, SYM_MOD - 1), 1'b1,
             $urandom_range(0, 3), $urandom_range(0, SYM_MOD - 1));
      else if (r < 25)
        step("rand.idle", 1'b0, $urandom_range(0, SYM_MOD - 1));
      else
        step("rand.sym", 1'b1, $urandom_range(0, SYM_MOD - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
